// File: rtl/div_round_pack.sv
// div_round_pack: rounding, exponent adjust and packing stage of the FP divider.
// Two-stage valid/ready pipeline: stage 1 decides the rounding increment and the
// adjusted exponent, stage 2 applies the increment, range-checks and packs.
module div_round_pack #(
   parameter int sig_width = 23,
   parameter int exp_width = 8
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             sign,
   input  logic [exp_width+1:0]             exp_pre,
   input  logic [sig_width:0]               quotient,
   input  logic                             guard_bit,
   input  logic                             round_bit,
   input  logic                             sticky_bit,
   input  logic                             count,
   input  logic                             spec_nan,
   input  logic                             spec_inf,
   input  logic                             spec_zero,
   input  logic [2:0]                       rnd_mode,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [exp_width+sig_width:0]     result,
   output logic [3:0]                       flags
);

   localparam int EW2 = exp_width + 2;
   localparam int RW  = 1 + exp_width + sig_width;

   localparam logic [2:0] RNE = 3'd0;
   localparam logic [2:0] RTZ = 3'd1;
   localparam logic [2:0] RDN = 3'd2;
   localparam logic [2:0] RUP = 3'd3;
   localparam logic [2:0] RMM = 3'd4;

   localparam logic signed [EW2-1:0] EMAX = EW2'((1 << exp_width) - 1);

   // stage 1 state
   logic                   v1_q;
   logic                   s1_sign_q;
   logic signed [EW2-1:0]  s1_e_q;
   logic [sig_width:0]     s1_quo_q;
   logic                   s1_inc_q;
   logic                   s1_inx_q;
   logic                   s1_nan_q;
   logic                   s1_inf_q;
   logic                   s1_zero_q;
   logic [2:0]             s1_mode_q;

   // stage 2 state
   logic                   v2_q;
   logic [RW-1:0]          result_q;
   logic [3:0]             flags_q;

   logic                   s2_adv;
   logic                   s1_adv;

   assign s2_adv    = !v2_q || out_ready;
   assign s1_adv    = !v1_q || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = v2_q;
   assign result    = result_q;
   assign flags     = flags_q;

   // stage 1 combinational: mode normalisation, increment decision, exponent adjust
   logic [2:0]             mode_d;
   logic                   inc_d;
   logic                   inx_d;
   logic signed [EW2-1:0]  e1_d;

   always_comb begin
      mode_d = (rnd_mode > RMM) ? RNE : rnd_mode;
      inx_d  = guard_bit | round_bit | sticky_bit;
      e1_d   = $signed(exp_pre) - $signed({{(EW2-1){1'b0}}, count});
      case (mode_d)
         RTZ:     inc_d = 1'b0;
         RDN:     inc_d = sign & inx_d;
         RUP:     inc_d = !sign & inx_d;
         RMM:     inc_d = guard_bit;
         default: inc_d = guard_bit & (round_bit | sticky_bit | quotient[0]);
      endcase
   end

   // stage 1 register: loads on an input transfer
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         v1_q      <= 1'b0;
         s1_sign_q <= 1'b0;
         s1_e_q    <= '0;
         s1_quo_q  <= '0;
         s1_inc_q  <= 1'b0;
         s1_inx_q  <= 1'b0;
         s1_nan_q  <= 1'b0;
         s1_inf_q  <= 1'b0;
         s1_zero_q <= 1'b0;
         s1_mode_q <= '0;
      end else if (s1_adv) begin
         v1_q <= in_valid;
         if (in_valid) begin
            s1_sign_q <= sign;
            s1_e_q    <= e1_d;
            s1_quo_q  <= quotient;
            s1_inc_q  <= inc_d;
            s1_inx_q  <= inx_d;
            s1_nan_q  <= spec_nan;
            s1_inf_q  <= spec_inf;
            s1_zero_q <= spec_zero;
            s1_mode_q <= mode_d;
         end
      end
   end

   // stage 2 combinational: apply increment, range check, select packed result
   logic                   carry;
   logic [sig_width-1:0]   frac;
   logic signed [EW2-1:0]  e2;
   logic                   ovf;
   logic                   unf;
   logic                   ovf_inf;
   logic [RW-1:0]          inf_word;
   logic [RW-1:0]          max_word;
   logic [RW-1:0]          zero_word;
   logic [RW-1:0]          nan_word;
   logic [RW-1:0]          result_d;
   logic [3:0]             flags_d;

   always_comb begin
      // Carry out of quotient+inc only happens for an all-ones quotient; the
      // fraction then wraps to zero on its own.
      carry     = (&s1_quo_q) & s1_inc_q;
      frac      = s1_quo_q[sig_width-1:0] + {{(sig_width-1){1'b0}}, s1_inc_q};
      e2        = s1_e_q + $signed({{(EW2-1){1'b0}}, carry});
      ovf       = (e2 >= EMAX);
      unf       = e2[EW2-1] || (e2 == '0);
      ovf_inf   = (s1_mode_q == RNE) || (s1_mode_q == RMM) ||
                  ((s1_mode_q == RUP) && !s1_sign_q) ||
                  ((s1_mode_q == RDN) && s1_sign_q);
      inf_word  = {s1_sign_q, {exp_width{1'b1}}, {sig_width{1'b0}}};
      max_word  = {s1_sign_q, {(exp_width-1){1'b1}}, 1'b0, {sig_width{1'b1}}};
      zero_word = {s1_sign_q, {(exp_width+sig_width){1'b0}}};
      nan_word  = {1'b0, {exp_width{1'b1}}, 1'b1, {(sig_width-1){1'b0}}};
      result_d  = {s1_sign_q, e2[exp_width-1:0], frac};
      flags_d   = {3'b000, s1_inx_q};
      if (s1_nan_q) begin
         result_d = nan_word;
         flags_d  = 4'b1000;
      end else if (s1_inf_q) begin
         result_d = inf_word;
         flags_d  = 4'b0000;
      end else if (s1_zero_q) begin
         result_d = zero_word;
         flags_d  = 4'b0000;
      end else if (ovf) begin
         result_d = ovf_inf ? inf_word : max_word;
         flags_d  = 4'b0101;
      end else if (unf) begin
         result_d = zero_word;
         flags_d  = 4'b0011;
      end
   end

   // stage 2 register: loads on a stage 1 -> stage 2 transfer, holds while stalled
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         v2_q     <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else if (s2_adv) begin
         v2_q <= v1_q;
         if (v1_q) begin
            result_q <= result_d;
            flags_q  <= flags_d;
         end
      end
   end

endmodule

// File: tb/tb_div_round_pack.sv
// Directed bench for div_round_pack with hand-computed single-precision results.
module tb_div_round_pack;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic        sign;
   logic [9:0]  exp_pre;
   logic [23:0] quotient;
   logic        guard_bit, round_bit, sticky_bit;
   logic        count;
   logic        spec_nan, spec_inf, spec_zero;
   logic [2:0]  rnd_mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [3:0]  flags;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   div_round_pack #(.sig_width(23), .exp_width(8)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .sign(sign), .exp_pre(exp_pre), .quotient(quotient),
      .guard_bit(guard_bit), .round_bit(round_bit), .sticky_bit(sticky_bit),
      .count(count), .spec_nan(spec_nan), .spec_inf(spec_inf), .spec_zero(spec_zero),
      .rnd_mode(rnd_mode), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flags(flags)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic set_word(input logic sg, input logic [9:0] ep, input logic [23:0] q,
                           input logic [2:0] grs, input logic cnt, input logic [2:0] spc,
                           input logic [2:0] md);
      sign = sg; exp_pre = ep; quotient = q;
      {guard_bit, round_bit, sticky_bit} = grs;
      count = cnt; {spec_nan, spec_inf, spec_zero} = spc; rnd_mode = md;
   endtask

   // one word through an unstalled pipe; checks latency, result and flags
   task automatic run_vec(input string tag, input logic sg, input logic [9:0] ep,
                          input logic [23:0] q, input logic [2:0] grs, input logic cnt,
                          input logic [2:0] spc, input logic [2:0] md,
                          input logic [31:0] er, input logic [3:0] ef);
      int lat;
      @(negedge clk);
      set_word(sg, ep, q, grs, cnt, spc, md);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'd2);
      chk({tag, "_res"}, result, er);
      chk({tag, "_flg"}, {28'd0, flags}, {28'd0, ef});
   endtask

   initial begin
      int idx, stalls, outs, guard;
      resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      set_word(1'b0, 10'd0, 24'd0, 3'b000, 1'b0, 3'b000, 3'd0);
      #12;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_flags", {28'd0, flags}, 32'd0);
      chk("rst_inrdy", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      resetn = 1'b1;

      //        tag             sg  exp_pre  quotient     grs   cnt spc     md    result        flags
      run_vec("one",           0, 10'd127, 24'h800000, 3'b000, 0, 3'b000, 3'd0, 32'h3F800000, 4'h0);
      run_vec("rne_tie_odd",   0, 10'd127, 24'h800001, 3'b100, 0, 3'b000, 3'd0, 32'h3F800002, 4'h1);
      run_vec("rne_tie_even",  0, 10'd127, 24'h800000, 3'b100, 0, 3'b000, 3'd0, 32'h3F800000, 4'h1);
      run_vec("rne_above",     0, 10'd127, 24'h800000, 3'b110, 0, 3'b000, 3'd0, 32'h3F800001, 4'h1);
      run_vec("carry_ovf_rne", 0, 10'd254, 24'hFFFFFF, 3'b100, 0, 3'b000, 3'd0, 32'h7F800000, 4'h5);
      run_vec("carry_rtz",     0, 10'd254, 24'hFFFFFF, 3'b100, 0, 3'b000, 3'd1, 32'h7F7FFFFF, 4'h1);
      run_vec("ovf_rtz",       0, 10'd255, 24'h800000, 3'b000, 0, 3'b000, 3'd1, 32'h7F7FFFFF, 4'h5);
      run_vec("ovf_rup_neg",   1, 10'd255, 24'h800000, 3'b000, 0, 3'b000, 3'd3, 32'hFF7FFFFF, 4'h5);
      run_vec("ovf_rup_pos",   0, 10'd255, 24'h800000, 3'b000, 0, 3'b000, 3'd3, 32'h7F800000, 4'h5);
      run_vec("ovf_rdn_neg",   1, 10'd255, 24'h800000, 3'b000, 0, 3'b000, 3'd2, 32'hFF800000, 4'h5);
      run_vec("ovf_rdn_pos",   0, 10'd255, 24'h800000, 3'b000, 0, 3'b000, 3'd2, 32'h7F7FFFFF, 4'h5);
      run_vec("unf",           1, 10'd1,   24'h800000, 3'b000, 1, 3'b000, 3'd0, 32'h80000000, 4'h3);
      run_vec("unf_negexp",    0, 10'h3FB, 24'h800000, 3'b000, 0, 3'b000, 3'd0, 32'h00000000, 4'h3);
      run_vec("min_norm",      0, 10'd1,   24'h800000, 3'b000, 0, 3'b000, 3'd0, 32'h00800000, 4'h0);
      run_vec("nan",           1, 10'd255, 24'h800000, 3'b111, 0, 3'b100, 3'd0, 32'h7FC00000, 4'h8);
      run_vec("inf_over_zero", 1, 10'd127, 24'h800000, 3'b000, 0, 3'b011, 3'd0, 32'hFF800000, 4'h0);
      run_vec("zero",          1, 10'd127, 24'h800000, 3'b111, 0, 3'b001, 3'd0, 32'h80000000, 4'h0);
      run_vec("rdn_neg",       1, 10'd127, 24'h800000, 3'b001, 0, 3'b000, 3'd2, 32'hBF800001, 4'h1);
      run_vec("rdn_pos",       0, 10'd127, 24'h800000, 3'b001, 0, 3'b000, 3'd2, 32'h3F800000, 4'h1);
      run_vec("rup_pos",       0, 10'd127, 24'h800000, 3'b010, 0, 3'b000, 3'd3, 32'h3F800001, 4'h1);
      run_vec("rmm",           0, 10'd127, 24'h800000, 3'b100, 0, 3'b000, 3'd4, 32'h3F800001, 4'h1);
      run_vec("mode7_rne",     0, 10'd127, 24'h800000, 3'b100, 0, 3'b000, 3'd7, 32'h3F800000, 4'h1);
      run_vec("count_norm",    0, 10'd128, 24'hC00000, 3'b000, 1, 3'b000, 3'd0, 32'h3FC00000, 4'h0);
      run_vec("rtz_inexact",   0, 10'd127, 24'h800001, 3'b111, 0, 3'b000, 3'd1, 32'h3F800001, 4'h1);

      // back-pressure: 4 words, downstream stalled for the first 5 cycles
      @(negedge clk);
      idx = 0; stalls = 0;
      fork
         begin : drv
            int i, g;
            i = 0; g = 0;
            while (i < 4 && g < 50) begin
               @(negedge clk);
               set_word(1'b0, 10'd127, 24'h800000 + 24'(i), 3'b000, 1'b0, 3'b000, 3'd0);
               in_valid = 1'b1;
               #1;
               if (in_ready) i++;
               @(posedge clk);
               g++;
            end
            @(negedge clk);
            in_valid = 1'b0;
         end
         begin : mon
            for (int k = 0; k < 40 && idx < 4; k++) begin
               @(negedge clk);
               out_ready = (k >= 5);
               #1;
               if (k == 2) chk("bp_inrdy_drop", {31'd0, in_ready}, 32'd0);
               if (out_valid) begin
                  chk($sformatf("bp_word%0d", idx), result, 32'h3F800000 + 32'(idx));
                  if (!out_ready) stalls++;
                  else idx++;
               end
            end
         end
      join
      chk("bp_count", 32'(idx), 32'd4);
      chk("bp_stalls", 32'(stalls), 32'd3);
      outs = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (out_valid) outs++;
      end
      chk("bp_no_extra", 32'(outs), 32'd0);

      // reset with two words in flight
      out_ready = 1'b0;
      @(negedge clk);
      set_word(1'b0, 10'd127, 24'h800005, 3'b000, 1'b0, 3'b000, 3'd0);
      in_valid = 1'b1;
      @(negedge clk);
      set_word(1'b0, 10'd127, 24'h800006, 3'b000, 1'b0, 3'b000, 3'd0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("rst_pre_valid", {31'd0, out_valid}, 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_result", result, 32'd0);
      chk("rst_mid_flags", {28'd0, flags}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      out_ready = 1'b1;
      outs = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (out_valid) outs++;
      end
      chk("rst_no_emit", 32'(outs), 32'd0);
      chk("rst_inrdy_after", {31'd0, in_ready}, 32'd1);

      guard = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
